fc_layer_backward: RTL and testbench

Serial backward-pass engine for the fully connected layer. It takes the layer's stored input activations, weights and bias, plus an output error `delta` and a learning rate. It produces, one index per cycle:
- the input gradient `delta*w[i]`, passed back to the previous layer;
- the SGD-updated weight `w[i] - lr*delta*x[i]`.

It also produces the updated bias `bias - lr*delta`. It sits beside the forward layer in the training path and uses the same Q16.16 fixed-point format.

---
 rtl/fc_layer_backward.sv | 167 ++++++++++++++++
 tb/tb_fc_layer_backward.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_backward.sv
// Serial backward pass for a fully connected layer in Q16.16 sign-magnitude.
// Streams the input gradient and the SGD-updated weight for one index per cycle, then the new bias.
module fc_layer_backward #(
  parameter int input_size  = 32,
  parameter int index_width = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [input_size-1:0][31:0]  input_data,
  input  logic [input_size-1:0][31:0]  weight,
  input  logic [31:0]                  bias,
  input  logic [31:0]                  delta,
  input  logic [31:0]                  learning_rate,
  output logic                         busy,
  output logic                         out_valid,
  output logic [index_width-1:0]       out_index,
  output logic [31:0]                  grad_input,
  output logic [31:0]                  weight_new,
  output logic [31:0]                  bias_new,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [index_width-1:0] LAST_IDX = index_width'(input_size - 1);

  state_t state, state_next;
  logic   capture, issue, finish;

  logic [input_size-1:0][31:0] x_r, w_r;
  logic [31:0]                 bias_r, delta_r, lr_r;
  logic [index_width-1:0]      idx;

  logic                        s1_valid;
  logic [index_width-1:0]      s1_idx;
  logic [31:0]                 s1_gw, s1_gi, s1_w;

  // Truncating product; anything that does not fit in 31 magnitude bits clamps to full scale.
  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    logic [61:0] prod;
    logic [45:0] shifted;
    logic [30:0] mag;
    prod    = {31'd0, a[30:0]} * {31'd0, b[30:0]};
    shifted = prod[61:16];
    if (|shifted[45:31]) mag = '1;
    else                 mag = shifted[30:0];
    return {(a[31] ^ b[31]) & (|mag), mag};
  endfunction

  function automatic logic [31:0] q_sub(input logic [31:0] a, input logic [31:0] b);
    logic        b_sign;
    logic        sign;
    logic [31:0] sum;
    logic [30:0] mag;
    b_sign = ~b[31];
    if (a[31] == b_sign) begin
      sum  = {1'b0, a[30:0]} + {1'b0, b[30:0]};
      mag  = sum[31] ? '1 : sum[30:0];
      sign = a[31];
    end else if (a[30:0] >= b[30:0]) begin
      mag  = a[30:0] - b[30:0];
      sign = a[31];
    end else begin
      mag  = b[30:0] - a[30:0];
      sign = b_sign;
    end
    return {sign & (|mag), mag};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (idx == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and index sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r     <= '0;
      w_r     <= '0;
      bias_r  <= '0;
      delta_r <= '0;
      lr_r    <= '0;
      idx     <= '0;
    end else if (capture) begin
      x_r     <= input_data;
      w_r     <= weight;
      bias_r  <= bias;
      delta_r <= delta;
      lr_r    <= learning_rate;
      idx     <= '0;
    end else if (issue) begin
      idx     <= idx + index_width'(1);
    end
  end

  // Stage 1: both delta products for the issued index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_gw    <= '0;
      s1_gi    <= '0;
      s1_w     <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_idx <= idx;
        s1_gw  <= q_mul(delta_r, x_r[idx]);
        s1_gi  <= q_mul(delta_r, w_r[idx]);
        s1_w   <= w_r[idx];
      end
    end
  end

  // Stage 2 plus bias; busy stays up through the done cycle so it brackets every output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_index  <= '0;
      grad_input <= '0;
      weight_new <= '0;
      bias_new   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index  <= s1_idx;
        grad_input <= s1_gi;
        weight_new <= q_sub(s1_w, q_mul(lr_r, s1_gw));
      end
      done <= finish;
      if (finish) bias_new <= q_sub(bias_r, q_mul(lr_r, delta_r));
      busy <= (state_next != IDLE) || (state == DRAIN);
    end
  end

endmodule

// File: tb/tb_fc_layer_backward.sv
// Randomized self-checking bench for fc_layer_backward against a signed-integer model of the Q16.16 rules.
module tb_fc_layer_backward;
  localparam int N  = 32;
  localparam int IW = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [N-1:0][31:0]   input_data = '0;
  logic [N-1:0][31:0]   weight = '0;
  logic [31:0]          bias = '0, delta = '0, learning_rate = '0;
  logic                 busy, out_valid, done;
  logic [IW-1:0]        out_index;
  logic [31:0]          grad_input, weight_new, bias_new;

  int passed = 0;
  int total  = 0;

  logic [N-1:0][31:0]   m_x, m_w;
  logic [31:0]          m_bias, m_delta, m_lr;

  int                   got_idx[$];
  int                   got_cyc[$];
  logic [31:0]          got_gi[$];
  logic [31:0]          got_wn[$];
  int                   done_cnt, done_cycle;
  logic                 done_with_last, busy_gap, busy_after;
  logic [31:0]          got_bias;

  fc_layer_backward #(.input_size(N), .index_width(IW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .input_data(input_data), .weight(weight), .bias(bias), .delta(delta),
    .learning_rate(learning_rate), .busy(busy), .out_valid(out_valid),
    .out_index(out_index), .grad_input(grad_input), .weight_new(weight_new),
    .bias_new(bias_new), .done(done)
  );

  always #5 clk = ~clk;

  function automatic longint to_val(input logic [31:0] q);
    return q[31] ? -longint'(q[30:0]) : longint'(q[30:0]);
  endfunction

  function automatic logic [31:0] from_val(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > 64'sh7FFFFFFF) m = 64'sh7FFFFFFF;
    if (m == 0) return 32'h0;
    return {v < 0, m[30:0]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    longint p, m;
    p = to_val(a) * to_val(b);
    m = ((p < 0) ? -p : p) >> 16;
    return from_val((p < 0) ? -m : m);
  endfunction

  function automatic logic [31:0] model_sub(input logic [31:0] a, input logic [31:0] b);
    return from_val(to_val(a) - to_val(b));
  endfunction

  function automatic logic [31:0] exp_grad(input int i);
    return model_mul(m_delta, m_w[i]);
  endfunction

  function automatic logic [31:0] exp_wnew(input int i);
    return model_sub(m_w[i], model_mul(m_lr, model_mul(m_delta, m_x[i])));
  endfunction

  function automatic logic [31:0] rand_q();
    logic [31:0] r;
    r     = $urandom >> $urandom_range(1, 24);
    r[31] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      input_data[i] = rand_q();
      weight[i]     = rand_q();
    end
    bias          = rand_q();
    delta         = rand_q();
    learning_rate = rand_q();
  endtask

  // Starts one operation and records what comes out; count 0 is the cycle after the start edge
  task automatic run_op(input int pulse_at);
    got_idx.delete(); got_cyc.delete(); got_gi.delete(); got_wn.delete();
    done_cnt = 0; done_cycle = -1; done_with_last = 1'b0;
    busy_gap = 1'b0; busy_after = 1'bx; got_bias = 'x;
    @(negedge clk);
    m_x = input_data; m_w = weight; m_bias = bias; m_delta = delta; m_lr = learning_rate;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < N + 8; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        got_idx.push_back(int'(out_index));
        got_cyc.push_back(c);
        got_gi.push_back(grad_input);
        got_wn.push_back(weight_new);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle     = c;
          done_with_last = (out_valid === 1'b1) && (out_index === IW'(N - 1));
          got_bias       = bias_new;
        end
      end
      if (c <= N + 1 && busy !== 1'b1) busy_gap = 1'b1;
      if (c == N + 2) busy_after = busy;
      if (c == pulse_at) begin
        start = 1'b1;
        rand_ops();
      end else if (c == pulse_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, out_valid, done, out_index, grad_input, weight_new, bias_new} !== '0)
      $display("[TB] FAIL reset_outputs: got busy=%b valid=%b done=%b idx=%0d gi=%h wn=%h bn=%h required all zero",
               busy, out_valid, done, out_index, grad_input, weight_new, bias_new);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    rand_ops();
    delta = 32'h00010000; learning_rate = 32'h00008000; bias = 32'h00030000;
    input_data[0] = 32'h00020000; weight[0] = 32'h00010000;
    run_op(-1);
    total++; if (got_gi[0] !== 32'h00010000) $display("[TB] FAIL basic_grad0: got %h required %h", got_gi[0], 32'h00010000); else passed++;
    total++; if (got_wn[0] !== 32'h00000000) $display("[TB] FAIL basic_wnew0: got %h required %h", got_wn[0], 32'h00000000); else passed++;
    total++; if (got_bias !== 32'h00028000) $display("[TB] FAIL basic_bias: got %h required %h", got_bias, 32'h00028000); else passed++;
    total++; if (done_cycle != N + 1) $display("[TB] FAIL basic_done_cycle: got %0d required %0d", done_cycle, N + 1); else passed++;
    total++; if (got_cyc[0] != 2) $display("[TB] FAIL basic_first_valid_cycle: got %0d required 2", got_cyc[0]); else passed++;
    total++; if (busy_gap !== 1'b0 || busy_after !== 1'b0) $display("[TB] FAIL basic_busy: got gap=%b after=%b required 0 0", busy_gap, busy_after); else passed++;
  endtask

  task automatic test_signs();
    for (int i = 0; i < N; i++) begin
      input_data[i] = 32'h00010000;
      weight[i]     = 32'h00004000;
    end
    delta = 32'h80010000; learning_rate = 32'h00010000; bias = rand_q();
    run_op(-1);
    total++; if (got_gi.size() != N) $display("[TB] FAIL signs_count: got %0d required %0d", got_gi.size(), N); else passed++;
    for (int i = 0; i < got_gi.size(); i++) begin
      total++; if (got_gi[i] !== 32'h80004000) $display("[TB] FAIL signs_grad[%0d]: got %h required %h", i, got_gi[i], 32'h80004000); else passed++;
      total++; if (got_wn[i] !== 32'h00014000) $display("[TB] FAIL signs_wnew[%0d]: got %h required %h", i, got_wn[i], 32'h00014000); else passed++;
    end
  endtask

  task automatic test_saturation();
    rand_ops();
    delta = 32'h40000000; weight[2] = 32'h40000000;
    run_op(-1);
    total++; if (got_gi[2] !== 32'h7FFFFFFF) $display("[TB] FAIL sat_grad2: got %h required %h", got_gi[2], 32'h7FFFFFFF); else passed++;
    total++; if (got_wn[2] !== exp_wnew(2)) $display("[TB] FAIL sat_wnew2: got %h required %h", got_wn[2], exp_wnew(2)); else passed++;
    rand_ops();
    delta = 32'h00000000; weight[1] = 32'h80010000;
    run_op(-1);
    total++; if (got_gi[1] !== 32'h00000000) $display("[TB] FAIL negzero_grad1: got %h required %h", got_gi[1], 32'h00000000); else passed++;
    total++; if (got_wn[1] !== 32'h80010000) $display("[TB] FAIL negzero_wnew1: got %h required %h", got_wn[1], 32'h80010000); else passed++;
    total++; if (got_bias !== m_bias) $display("[TB] FAIL negzero_bias: got %h required %h", got_bias, m_bias); else passed++;
  endtask

  task automatic test_streaming();
    for (int rep = 0; rep < 3; rep++) begin
      rand_ops();
      run_op(-1);
      total++; if (got_idx.size() != N) $display("[TB] FAIL stream_count: got %0d required %0d", got_idx.size(), N); else passed++;
      for (int i = 0; i < got_idx.size(); i++) begin
        total++; if (got_idx[i] != i || got_cyc[i] != 2 + i) $display("[TB] FAIL stream_index[%0d]: got idx %0d at cycle %0d required idx %0d at cycle %0d", i, got_idx[i], got_cyc[i], i, 2 + i); else passed++;
        total++; if (got_gi[i] !== exp_grad(i)) $display("[TB] FAIL stream_grad[%0d]: got %h required %h", i, got_gi[i], exp_grad(i)); else passed++;
        total++; if (got_wn[i] !== exp_wnew(i)) $display("[TB] FAIL stream_wnew[%0d]: got %h required %h", i, got_wn[i], exp_wnew(i)); else passed++;
      end
      total++; if (done_cnt != 1 || done_with_last !== 1'b1) $display("[TB] FAIL stream_done: got count %0d with_last %b required 1 1", done_cnt, done_with_last); else passed++;
      total++; if (got_bias !== model_sub(m_bias, model_mul(m_lr, m_delta))) $display("[TB] FAIL stream_bias: got %h required %h", got_bias, model_sub(m_bias, model_mul(m_lr, m_delta))); else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    int bad;
    rand_ops();
    run_op(2);
    bad = 0;
    for (int i = 0; i < got_idx.size(); i++)
      if (got_gi[i] !== exp_grad(i) || got_wn[i] !== exp_wnew(i)) bad++;
    total++; if (got_idx.size() != N || bad != 0) $display("[TB] FAIL busy_start_values: got %0d outputs with %0d wrong required %0d with 0 wrong", got_idx.size(), bad, N); else passed++;
    total++; if (done_cnt != 1 || done_cycle != N + 1) $display("[TB] FAIL busy_start_done: got count %0d at cycle %0d required 1 at %0d", done_cnt, done_cycle, N + 1); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic found;
    int   stray_done;
    rand_ops();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid === 1'b1 && out_index === IW'(5)) found = 1'b1;
      else @(negedge clk);
    end
    total++; if (!found) $display("[TB] FAIL reset_mid_reach_idx5: got timeout required index 5 within 40 cycles"); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, out_valid, done, out_index, grad_input, weight_new, bias_new} !== '0)
      $display("[TB] FAIL reset_mid_outputs: got busy=%b valid=%b done=%b idx=%0d gi=%h wn=%h bn=%h required all zero",
               busy, out_valid, done, out_index, grad_input, weight_new, bias_new);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray_done = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) stray_done++;
    end
    total++; if (stray_done != 0) $display("[TB] FAIL reset_mid_quiet: got %0d active cycles required 0", stray_done); else passed++;
    rand_ops();
    run_op(-1);
    total++; if (got_idx.size() != N || done_cycle != N + 1) $display("[TB] FAIL reset_restart_timing: got %0d outputs done at %0d required %0d at %0d", got_idx.size(), done_cycle, N, N + 1); else passed++;
    for (int i = 0; i < got_idx.size(); i++) begin
      total++; if (got_gi[i] !== exp_grad(i) || got_wn[i] !== exp_wnew(i)) $display("[TB] FAIL reset_restart[%0d]: got %h/%h required %h/%h", i, got_gi[i], got_wn[i], exp_grad(i), exp_wnew(i)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_streaming();
    test_start_while_busy();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
